mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 8-to-1 mux datapath.
- Eight requesters compete for one output channel; the block grants one at a time and drives the mux select.
- The selected requester's data is presented on a valid/ready output handshake.
- Sits between eight producer slots and one downstream consumer; the mux itself is the combinational datapath inside this block.

---
 rtl/mux8_rr_arbiter.sv | 102 ++++++++++
 tb/tb_mux8_rr_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 8-to-1 mux datapath.
// One requester at a time is granted; its lane is presented on a
// valid/ready output handshake. Completion or abort re-arbitrates on the
// same edge so back-to-back transfers carry no bubble cycle.
module mux8_rr_arbiter #(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          req,
  input  logic [8*DATA_W-1:0] in_data,
  input  logic                out_ready,
  output logic [7:0]          gnt,
  output logic [2:0]          sel,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [2:0]        ptr;
  logic [7:0]        cand;
  logic [2:0]        base;
  logic [2:0]        idx;
  logic [2:0]        winner;
  logic              found;
  logic              rel;
  logic [DATA_W-1:0] lanes [8];

  // Next-winner search: while a grant is held, the current holder is masked
  // out and the search starts just past it, which is exactly the pointer
  // value the releasing edge will store.
  always_comb begin
    cand   = req;
    base   = ptr;
    if (state == GRANT) begin
      cand[sel] = 1'b0;
      base      = sel + 3'd1;
    end
    idx    = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = base + 3'(k);
      if (!found && cand[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Grant is released on completion (ready with request held) or abort (request dropped).
  always_comb begin
    rel = (state == GRANT) && (!req[sel] || out_ready);
  end

  // Arbitration state machine: grant, pointer and select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= winner;
            gnt   <= 8'd1 << winner;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr <= sel + 3'd1;
            if (found) begin
              sel <= winner;
              gnt <= 8'd1 << winner;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // Split the packed input into lanes for the select mux.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      lanes[i] = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign out_data  = lanes[sel];
  assign out_valid = (state == GRANT);
  assign busy      = out_valid;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: expected per-cycle outputs are
// queued as stimulus is driven and compared one cycle after each edge.
module tb_mux8_rr_arbiter;

  localparam int DW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      req;
  logic [8*DW-1:0] in_data;
  logic            out_ready;
  logic [7:0]      gnt;
  logic [2:0]      sel;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            busy;

  typedef struct packed {
    logic          v;
    logic [2:0]    s;
    logic [7:0]    g;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mux8_rr_arbiter #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in_data   (in_data),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane(input logic [8*DW-1:0] d, input logic [2:0] s);
    return d[s*DW +: DW];
  endfunction

  task automatic push(input logic v, input logic [2:0] s, input logic [DW-1:0] d);
    exp_t e;
    e.v = v;
    e.s = s;
    e.g = v ? (8'd1 << s) : 8'd0;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    check({tag, "/sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "/valid"}, 32'(out_valid), 32'(e.v));
      check({tag, "/busy"},  32'(busy),      32'(e.v));
      check({tag, "/sel"},   32'(sel),       32'(e.s));
      check({tag, "/gnt"},   32'(gnt),       32'(e.g));
      check({tag, "/data"},  32'(out_data),  32'(e.d));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pv;
    logic [2:0] sv;

    rst = 1'b1; req = '0; out_ready = 1'b0; in_data = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    check("reset/gnt",   32'(gnt),       32'd0);
    check("reset/sel",   32'(sel),       32'd0);
    check("reset/valid", 32'(out_valid), 32'd0);
    check("reset/busy",  32'(busy),      32'd0);
    check("reset/data",  32'(out_data),  32'd1);
    rst = 1'b0;

    // Round-robin with all requesting: 0..7 then wrap to 0,1.
    in_data = 8'hA5; req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sv = 3'(i % 8);
      push(1'b1, sv, lane(in_data, sv));
      tick("rr");
    end

    // Asynchronous reset while a grant is held.
    #2 rst = 1'b1;
    #1;
    check("async_rst/gnt",   32'(gnt),       32'd0);
    check("async_rst/valid", 32'(out_valid), 32'd0);
    check("async_rst/sel",   32'(sel),       32'd0);
    check("async_rst/busy",  32'(busy),      32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    push(1'b1, 3'd0, lane(in_data, 3'd0));
    tick("rst_restart");
    req = '0;
    push(1'b0, 3'd0, lane(in_data, 3'd0));
    tick("rst_idle");

    // Single requester 5, completion, then ptr=6 beats requester 0.
    in_data = 8'h20; req = 8'h20; out_ready = 1'b1;
    push(1'b1, 3'd5, 1'b1);
    tick("single_grant");
    push(1'b0, 3'd5, 1'b1);
    tick("single_done");
    req = 8'h41; in_data = 8'h40;
    push(1'b1, 3'd6, 1'b1);
    tick("ptr6");
    req = '0;
    push(1'b0, 3'd6, 1'b1);
    tick("ptr6_idle");

    // Backpressure from ptr=0 with requesters 0 and 7.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    in_data = 8'h01; req = 8'h81; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 3'd0, 1'b1);
      tick("bp_hold");
      in_data[7] = ~in_data[7];
    end
    in_data = 8'h01; out_ready = 1'b1;
    push(1'b1, 3'd7, 1'b0);
    tick("bp_next7");
    push(1'b1, 3'd0, 1'b1);
    tick("bp_wrap0");
    req = '0;
    push(1'b0, 3'd0, 1'b1);
    tick("bp_idle");

    // Abort: grant 3, drop it with out_ready=0; ptr=4 makes 6 beat 2.
    in_data = 8'h08; req = 8'h08; out_ready = 1'b0;
    push(1'b1, 3'd3, 1'b1);
    tick("abort_g3");
    req = 8'h44; in_data = 8'h40;
    push(1'b1, 3'd6, 1'b1);
    tick("abort_to6");
    req = '0;
    push(1'b0, 3'd6, 1'b1);
    tick("abort_idle");

    // Datapath sweep: every select against every lane pattern.
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int p = 0; p < 256; p++) begin
        sv = 3'(s);
        pv = 8'(p);
        in_data = pv;
        req = 8'd1 << sv;
        push(1'b1, sv, pv[sv]);
        tick("dp_grant");
        push(1'b0, sv, pv[sv]);
        tick("dp_idle");
      end
    end
    req = '0;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
